bfp_conv_sched: RTL and testbench
=================================

# bfp_conv_sched

Two-requester scheduler that shares one block-floating-point conversion pipeline (vector transposer → largest-exponent finder → mantissa aligner) between two vector producers. It arbitrates round-robin and latches the winning vector. It then drives the transposer's load handshake, tags the aligned-mantissa beat stream with the requester ID, and checks that each job returns exactly V/P beats. It sits between the operand sources and the dot-product MAC stage.

## Interface
- V, 8, elements per vector
- P, 2, elements per pipeline beat; V must be a multiple of P
- BIT, 32, float width
- FPM, 23, float mantissa bits; exponent width is BIT-FPM-1
- BFPM, 4, block mantissa bits; beat element width is BFPM+2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- req  in  2  request per requester; held until granted
- vec0, vec1  in  V×BIT  vector of requester 0 / 1; sampled only at grant
- grant  out  2  one-hot, one-cycle pulse on acceptance
- busy  out  1  high whenever state ≠ IDLE
- pipe_vector  out  V×BIT  latched vector to transposer
- pipe_vector_rdy  out  1  transposer load request
- pipe_tran_done  in  1  transposer finished consuming vector
- pipe_mant_valid  in  1  aligned beat valid
- pipe_mants  in  P×(BFPM+2)  aligned mantissas
- pipe_exp  in  BIT-FPM-1  shared exponent
- pipe_mant_done  in  1  aligner finished job
- out_valid, out_id, out_last  out  1 each  tagged beat, requester ID, final beat
- out_mants  out  P×(BFPM+2); out_exp  out  BIT-FPM-1
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - If any req bit is set at the edge, pick the winner. Priority goes to requester `ptr`; the other wins only if `ptr` is not requesting.
  - Latch the winner's vec into pipe_vector and its ID into `cur_id`.
  - Set `ptr` to ~winner, pulse grant[winner], clear the beat counter, and go to LOAD.
- LOAD: pipe_vector_rdy = (state==LOAD) & ~pipe_tran_done, combinational. When pipe_tran_done is sampled high, go to DRAIN.
- LOAD and DRAIN beat handling: on each pipe_mant_valid, register pipe_mants and pipe_exp into out_mants and out_exp. Set out_id = cur_id, increment the counter, and set out_last when the counter reaches V/P.
- DRAIN: when pipe_mant_done is sampled high, go to IDLE.
- err is set and held until reset on any of these:
  - pipe_mant_valid while IDLE
  - a beat that would make the count exceed V/P; this beat is dropped, with no out_valid
  - pipe_mant_done with count ≠ V/P
  - pipe_mant_done while in LOAD; the FSM still moves to IDLE
- The counter is ceil(log2(V/P+1)) bits wide; it never wraps because overflow beats are dropped.

## Timing
- Reset values:
  - grant=0, busy=0, pipe_vector_rdy=0, pipe_vector=0
  - out_valid=0, out_last=0, out_id=0, out_mants=0, out_exp=0
  - err=0, ptr=0, state IDLE
- Grant latency: req sampled at edge k. grant and busy are high in cycle k+1, and pipe_vector_rdy goes high in cycle k+1.
- Output latency: each out_valid follows the corresponding pipe_mant_valid by exactly one cycle. out_valid lasts one cycle per beat.
- Inter-job gap:
  - pipe_mant_done sampled at edge m puts the FSM in IDLE for cycle m+1.
  - A pending req is granted at edge m+1, giving a minimum one-cycle gap.
  - A beat arriving in the same cycle as pipe_mant_done is still forwarded.
- Simultaneous events:
  - Both reqs high: the winner is `ptr`, and the loser stays pending.
  - pipe_tran_done and pipe_mant_valid in the same cycle: the beat is accepted and the state moves to DRAIN.
- Reset mid-operation: asynchronous. All outputs drop to reset values immediately, and any in-flight job is abandoned. The bench must also reset the pipeline.

## Test plan
- Single job:
  - Stimulus: req0 with vec0 = {3FC00000, 40200000, 40600000, 40900000} repeated (1.5, 2.5, 3.5, 4.5 ×2).
  - Response: grant=01 for one cycle. pipe_vector_rdy stays high until tran_done. Four out_valid beats follow, each with out_id=0 and out_exp=0x81, and only the 4th has out_last. busy returns to 0 and err stays 0.
- Contention:
  - Stimulus: req=11 out of reset.
  - Response: grant=01 first. grant=10 comes one cycle after the first job's pipe_mant_done. Beats are tagged 0 then 1.
- Fairness:
  - Stimulus: hold req=11 for 4 jobs.
  - Response: grants alternate 01, 10, 01, 10.
- Short stream:
  - Stimulus: pipeline model issues 3 beats, then pipe_mant_done.
  - Response: err=1, held through later jobs until reset.
- Overrun and stray beats:
  - Stimulus: pipeline model issues a 5th beat; separately, a beat arrives while IDLE.
  - Response: the extra beat produces no out_valid, and err=1.
- Reset mid-DRAIN:
  - Stimulus: assert reset low after beat 2.
  - Response: all outputs are 0 in the same cycle. After release, a new req0 is granted with a fresh count, and 4 beats complete normally.

Source files
------------

// File: rtl/bfp_conv_sched.sv
// Round-robin scheduler sharing one BFP conversion pipeline between two
// vector producers; tags aligned beats with requester ID, checks beat count.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   req[1:0]              per-requester request, held until granted
//   vec0, vec1            requester vectors, sampled at grant
//   grant[1:0]            one-hot grant pulse
//   busy                  scheduler not idle
//   pipe_vector(_rdy)     latched vector and transposer load request
//   pipe_tran_done        transposer consumed the vector
//   pipe_mant_valid/_mants/_exp/_done  aligned beat stream from pipeline
//   out_valid/_id/_last/_mants/_exp   tagged beat stream to MAC stage
//   err                   sticky protocol error
module bfp_conv_sched #(
    parameter int V    = 8,
    parameter int P    = 2,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req,
    input  logic [V*BIT-1:0]          vec0,
    input  logic [V*BIT-1:0]          vec1,
    output logic [1:0]                grant,
    output logic                      busy,
    output logic [V*BIT-1:0]          pipe_vector,
    output logic                      pipe_vector_rdy,
    input  logic                      pipe_tran_done,
    input  logic                      pipe_mant_valid,
    input  logic [P*(BFPM+2)-1:0]     pipe_mants,
    input  logic [BIT-FPM-2:0]        pipe_exp,
    input  logic                      pipe_mant_done,
    output logic                      out_valid,
    output logic                      out_id,
    output logic                      out_last,
    output logic [P*(BFPM+2)-1:0]     out_mants,
    output logic [BIT-FPM-2:0]        out_exp,
    output logic                      err
);

    localparam int NB = V / P;
    localparam int CW = $clog2(NB + 1);
    localparam int MW = P * (BFPM + 2);
    localparam int EW = BIT - FPM - 1;
    localparam logic [CW-1:0] NB_C = CW'(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               cur_id_q, cur_id_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic [V*BIT-1:0]   vec_q, vec_d;
    logic               out_valid_q, out_valid_d;
    logic               out_id_q, out_id_d;
    logic               out_last_q, out_last_d;
    logic [MW-1:0]      out_mants_q, out_mants_d;
    logic [EW-1:0]      out_exp_q, out_exp_d;
    logic               err_q, err_d;
    logic               win;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        cnt_d       = cnt_q;
        grant_d     = 2'b00;
        vec_d       = vec_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_last_d  = 1'b0;
        out_mants_d = out_mants_q;
        out_exp_d   = out_exp_q;
        err_d       = err_q;
        win         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pipe_mant_valid) err_d = 1'b1;
                if (|req) begin
                    // requester ptr has priority; the other wins only if ptr is quiet
                    win      = req[ptr_q] ? ptr_q : ~ptr_q;
                    grant_d  = win ? 2'b10 : 2'b01;
                    vec_d    = win ? vec1 : vec0;
                    cur_id_d = win;
                    ptr_d    = ~win;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD, S_DRAIN: begin
                if (pipe_mant_valid) begin
                    // overflow beats are dropped so the counter never wraps
                    if (cnt_q == NB_C) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + CW'(1);
                        out_valid_d = 1'b1;
                        out_mants_d = pipe_mants;
                        out_exp_d   = pipe_exp;
                        out_id_d    = cur_id_q;
                        out_last_d  = (cnt_d == NB_C);
                    end
                end
                if (pipe_mant_done) begin
                    // count includes a beat arriving alongside done
                    if (state_q == S_LOAD || cnt_d != NB_C) err_d = 1'b1;
                    state_d = S_IDLE;
                end else if (state_q == S_LOAD && pipe_tran_done) begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            cur_id_q    <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= 2'b00;
            vec_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
            out_mants_q <= '0;
            out_exp_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            vec_q       <= vec_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            out_mants_q <= out_mants_d;
            out_exp_q   <= out_exp_d;
            err_q       <= err_d;
        end
    end

    assign grant           = grant_q;
    assign busy            = (state_q != S_IDLE);
    assign pipe_vector     = vec_q;
    assign pipe_vector_rdy = (state_q == S_LOAD) & ~pipe_tran_done;
    assign out_valid       = out_valid_q;
    assign out_id          = out_id_q;
    assign out_last        = out_last_q;
    assign out_mants       = out_mants_q;
    assign out_exp         = out_exp_q;
    assign err             = err_q;

endmodule

// File: tb/tb_bfp_conv_sched.sv
// Self-checking bench for bfp_conv_sched: behavioural job-level model,
// per-cycle compare process and directed literal expectations.
module tb_bfp_conv_sched;

    localparam int V = 8, P = 2, BIT = 32, FPM = 23, BFPM = 4;
    localparam int NB = V / P;
    localparam int EL = BFPM + 2;
    localparam int MW = P * EL;
    localparam int EW = BIT - FPM - 1;

    logic             clk, reset;
    logic [1:0]       req;
    logic [V*BIT-1:0] vec0, vec1;
    logic [1:0]       grant;
    logic             busy;
    logic [V*BIT-1:0] pipe_vector;
    logic             pipe_vector_rdy;
    logic             pipe_tran_done, pipe_mant_valid, pipe_mant_done;
    logic [MW-1:0]    pipe_mants;
    logic [EW-1:0]    pipe_exp;
    logic             out_valid, out_id, out_last;
    logic [MW-1:0]    out_mants;
    logic [EW-1:0]    out_exp;
    logic             err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_g, last_d, gap_d;

    logic [1:0]    glog[$];
    logic          bid[$];
    logic          blast[$];
    logic [MW-1:0] bmant[$];
    logic [EW-1:0] bexp[$];

    bfp_conv_sched #(.V(V), .P(P), .BIT(BIT), .FPM(FPM), .BFPM(BFPM)) dut (
        .clk(clk), .reset(reset), .req(req), .vec0(vec0), .vec1(vec1),
        .grant(grant), .busy(busy), .pipe_vector(pipe_vector),
        .pipe_vector_rdy(pipe_vector_rdy), .pipe_tran_done(pipe_tran_done),
        .pipe_mant_valid(pipe_mant_valid), .pipe_mants(pipe_mants),
        .pipe_exp(pipe_exp), .pipe_mant_done(pipe_mant_done),
        .out_valid(out_valid), .out_id(out_id), .out_last(out_last),
        .out_mants(out_mants), .out_exp(out_exp), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [V*BIT-1:0] act,
                       input logic [V*BIT-1:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    // Pipeline stand-in: shared exponent and aligned, sign-tagged mantissas
    function automatic logic [EW-1:0] max_exp(input logic [V*BIT-1:0] v);
        logic [EW-1:0] mx, e;
        mx = '0;
        for (int i = 0; i < V; i++) begin
            e = v[i*BIT+FPM +: EW];
            if (e > mx) mx = e;
        end
        return mx;
    endfunction

    function automatic logic [MW-1:0] beat_of(input logic [V*BIT-1:0] v,
                                              input int b);
        logic [EW-1:0]  mx, e;
        logic [BIT-1:0] f;
        logic [BFPM:0]  m;
        logic [MW-1:0]  r;
        mx = max_exp(v);
        r  = '0;
        for (int k = 0; k < P; k++) begin
            f = v[(b*P+k)*BIT +: BIT];
            e = f[FPM +: EW];
            m = {1'b1, f[FPM-1 -: BFPM]} >> (mx - e);
            r[k*EL +: EL] = {f[BIT-1], m};
        end
        return r;
    endfunction

    // Behavioural model: one job at a time, round-robin, V/P beats per job
    logic             m_active, m_load, m_id, m_ptr, m_err, m_w;
    int               m_beats;
    logic [1:0]       e_grant;
    logic             e_valid, e_last, e_id;
    logic [MW-1:0]    e_mants;
    logic [EW-1:0]    e_exp;
    logic [V*BIT-1:0] e_vec;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_load = 0; m_id = 0; m_ptr = 0; m_err = 0;
            m_beats = 0; e_grant = 0; e_valid = 0; e_last = 0; e_id = 0;
            e_mants = 0; e_exp = 0; e_vec = 0;
        end else begin
            e_grant = 0;
            e_valid = 0;
            e_last  = 0;
            if (!m_active) begin
                if (pipe_mant_valid) m_err = 1;
                if (req != 0) begin
                    m_w      = req[m_ptr] ? m_ptr : !m_ptr;
                    e_grant  = m_w ? 2'b10 : 2'b01;
                    e_vec    = m_w ? vec1 : vec0;
                    m_id     = m_w;
                    m_ptr    = !m_w;
                    m_beats  = 0;
                    m_active = 1;
                    m_load   = 1;
                end
            end else begin
                if (pipe_mant_valid) begin
                    if (m_beats == NB) m_err = 1;
                    else begin
                        m_beats++;
                        e_valid = 1;
                        e_id    = m_id;
                        e_mants = pipe_mants;
                        e_exp   = pipe_exp;
                        e_last  = (m_beats == NB);
                    end
                end
                if (pipe_mant_done) begin
                    if (m_load || m_beats != NB) m_err = 1;
                    m_active = 0;
                    m_load   = 0;
                end else if (m_load && pipe_tran_done) begin
                    m_load = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("grant", grant, e_grant);
        chk("busy", busy, m_active);
        chk("vec", pipe_vector, e_vec);
        chk("rdy", pipe_vector_rdy, m_load & ~pipe_tran_done);
        chk("out_valid", out_valid, e_valid);
        chk("err", err, m_err);
        if (e_valid) begin
            chk("out_id", out_id, e_id);
            chk("out_last", out_last, e_last);
            chk("out_mants", out_mants, e_mants);
            chk("out_exp", out_exp, e_exp);
        end
        if (out_valid) begin
            bid.push_back(out_id);
            blast.push_back(out_last);
            bmant.push_back(out_mants);
            bexp.push_back(out_exp);
        end
    end

    task automatic clear_logs();
        glog.delete(); bid.delete(); blast.delete();
        bmant.delete(); bexp.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_rdy"}, pipe_vector_rdy, 0);
        chk({nm, "_vec"}, pipe_vector, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_last"}, out_last, 0);
        chk({nm, "_id"}, out_id, 0);
        chk({nm, "_mants"}, out_mants, 0);
        chk({nm, "_exp"}, out_exp, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0; req = 0;
        pipe_tran_done = 0; pipe_mant_valid = 0; pipe_mant_done = 0;
        @(posedge clk); #1;
        reset = 1;
    endtask

    // Acts as the conversion pipeline for one job
    task automatic pipe_job(input int nb, input bit overlap,
                            input bit clr, input int abort_at);
        int t;
        logic w;
        logic [V*BIT-1:0] v;
        t = 0;
        while (grant == 2'b00 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (grant == 2'b00) begin
            chk("grant_timeout", 1, 0);
            return;
        end
        w = grant[1];
        glog.push_back(grant);
        gap_d  = cyc - last_d;
        last_g = cyc;
        if (clr) req[w] = 1'b0;
        v = w ? vec1 : vec0;
        @(posedge clk); #1;
        if (!overlap) begin
            pipe_tran_done = 1;
            @(posedge clk); #1;
            pipe_tran_done = 0;
        end
        for (int b = 0; b < nb; b++) begin
            if (b == abort_at) begin
                pipe_mant_valid = 0;
                #2 reset = 0;
                #1 chk_zero("midrst");
                @(posedge clk); #1;
                reset = 1;
                return;
            end
            if (overlap && b == 0) pipe_tran_done = 1;
            pipe_mant_valid = 1;
            pipe_mants = beat_of(v, b % NB);
            pipe_exp = max_exp(v);
            @(posedge clk); #1;
            pipe_tran_done = 0;
        end
        pipe_mant_valid = 0;
        pipe_mant_done = 1;
        last_d = cyc;
        @(posedge clk); #1;
        pipe_mant_done = 0;
    endtask

    initial begin
        reset = 0; req = 0;
        vec0 = {4{32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000}};
        vec1 = {4{32'hC0000000, 32'h3F800000, 32'h41000000, 32'h3E800000}};
        pipe_tran_done = 0; pipe_mant_valid = 0; pipe_mant_done = 0;
        pipe_mants = 0; pipe_exp = 0;
        last_g = 0; last_d = 0; gap_d = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        chk_zero("reset");

        // single job from requester 0
        clear_logs();
        req = 2'b01;
        pipe_job(4, 0, 1, -1);
        chk("t1_nbeats", bid.size(), 4);
        chk("t1_grant", glog[0], 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_id%0d", i), bid[i], 0);
            chk($sformatf("t1_exp%0d", i), bexp[i], 8'h81);
            chk($sformatf("t1_last%0d", i), blast[i], i == 3);
        end
        chk("t1_mant0", bmant[0], 12'h286);
        chk("t1_mant1", bmant[1], 12'h48E);
        chk("t1_busy", busy, 0);
        chk("t1_err", err, 0);

        // contention out of reset
        do_reset();
        clear_logs();
        req = 2'b11;
        pipe_job(4, 0, 1, -1);
        pipe_job(4, 0, 1, -1);
        chk("t2_g0", glog[0], 2'b01);
        chk("t2_g1", glog[1], 2'b10);
        chk("t2_gap", gap_d, 2);
        chk("t2_nbeats", bid.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_id%0d", i), bid[i], i >= 4);

        // fairness with both requesters held
        clear_logs();
        req = 2'b11;
        for (int j = 0; j < 4; j++) pipe_job(4, j == 1, 0, -1);
        req = 2'b00;
        for (int j = 0; j < 4; j++)
            chk($sformatf("t3_g%0d", j), glog[j], (j % 2) ? 2'b10 : 2'b01);
        chk("t3_err", err, 0);

        // short stream, error sticky across next job
        req = 2'b01;
        pipe_job(3, 0, 1, -1);
        chk("t4_err", err, 1);
        req = 2'b10;
        pipe_job(4, 0, 1, -1);
        chk("t4_err_held", err, 1);

        // overrun beat
        do_reset();
        clear_logs();
        req = 2'b01;
        pipe_job(5, 0, 1, -1);
        chk("t5_nbeats", bid.size(), 4);
        chk("t5_err", err, 1);

        // stray beat while idle
        do_reset();
        clear_logs();
        pipe_mant_valid = 1;
        pipe_mants = 12'hABC;
        @(posedge clk); #1;
        pipe_mant_valid = 0;
        @(posedge clk); #1;
        chk("t5_stray_beats", bid.size(), 0);
        chk("t5_stray_err", err, 1);

        // reset in the middle of draining
        do_reset();
        req = 2'b01;
        pipe_job(4, 0, 1, 2);
        clear_logs();
        req = 2'b01;
        pipe_job(4, 0, 1, -1);
        chk("t6_nbeats", bid.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_last%0d", i), blast[i], i == 3);
        chk("t6_err", err, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
